// File: rtl/pacman_pkg.sv
// pacman_pkg
//   Shared definitions for the pacman front end and movement FSM.
//   Direction vectors are one-hot in the order {Left, Up, Right, Down}.
//   The movement FSM imports these instead of keeping its own copies.
package pacman_pkg;

    typedef logic [3:0] dir_t;

    localparam dir_t DIR_NONE  = 4'b0000;
    localparam dir_t DIR_LEFT  = 4'b1000;
    localparam dir_t DIR_UP    = 4'b0100;
    localparam dir_t DIR_RIGHT = 4'b0010;
    localparam dir_t DIR_DOWN  = 4'b0001;

    // Highest-priority set bit (Left > Up > Right > Down), returned one-hot.
    function automatic dir_t pick_dir(input dir_t req);
        dir_t res;
        res = DIR_NONE;
        if (req[3])      res = DIR_LEFT;
        else if (req[2]) res = DIR_UP;
        else if (req[1]) res = DIR_RIGHT;
        else if (req[0]) res = DIR_DOWN;
        return res;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer
//   2-FF synchroniser followed by a counter debouncer. The synchronised
//   input must differ from the accepted level for DEBOUNCE_CYCLES
//   consecutive cycles before it is accepted; any return to the accepted
//   level restarts the count.
// Ports
//   clk        in  system clock
//   reset      in  asynchronous, active-low reset
//   raw_in     in  raw (asynchronous, bouncy) button level
//   stable_out out debounced level
module button_debouncer
    import pacman_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250_000,
    parameter int CNT_W           = 21
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic stable_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            cnt        <= '0;
            stable_out <= 1'b0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
            if (sync2 == stable_out) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Differed for the full window: accept the new level.
                stable_out <= sync2;
                cnt        <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pacman_dir_input.sv
// pacman_dir_input
//   Board-pin front end for pacman_movement. Debounces the four direction
//   buttons and the centre button, arbitrates the directions into a single
//   one-hot level, emits a one-cycle centre-press pulse and paces moves with
//   a periodic move_tick.
// Ports
//   clk, reset              clock, asynchronous active-low reset
//   btn_l/u/r/d/c           raw buttons (async, bouncy)
//   tick_en                 1 = tick divider runs, 0 = divider held at 0
//   Left/Up/Right/Down      arbitrated direction, at most one high
//   center_pulse            1-cycle pulse on debounced press of btn_c
//   move_tick               1-cycle pulse every MOVE_DIV cycles while enabled
module pacman_dir_input
    import pacman_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250_000,
    parameter int MOVE_DIV        = 1_666_666,
    parameter int CNT_W           = 21
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_l,
    input  logic btn_u,
    input  logic btn_r,
    input  logic btn_d,
    input  logic btn_c,
    input  logic tick_en,
    output logic Left,
    output logic Up,
    output logic Right,
    output logic Down,
    output logic center_pulse,
    output logic move_tick
);

    localparam int NUM_BTN = 5;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(MOVE_DIV - 1);

    // Bit order {L, U, R, D, C} so [4:1] lines up with dir_t.
    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] stable;
    logic [NUM_BTN-1:0] stable_d;
    logic [NUM_BTN-1:0] rise;

    assign raw = {btn_l, btn_u, btn_r, btn_d, btn_c};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk       (clk),
            .reset     (reset),
            .raw_in    (raw[i]),
            .stable_out(stable[i])
        );
    end

    assign rise = stable & ~stable_d;

    // Direction arbiter: newest press wins, otherwise keep the current
    // direction while it is held, otherwise fall back to whatever is held.
    dir_t held;
    dir_t dir_q;
    dir_t dir_next;

    assign held = stable[4:1];

    always_comb begin
        dir_next = DIR_NONE;
        if (|rise[4:1])
            dir_next = pick_dir(rise[4:1]);
        else if (|(dir_q & held))
            dir_next = dir_q;
        else if (|held)
            dir_next = pick_dir(held);
    end

    logic [CNT_W-1:0] tick_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_d     <= '0;
            dir_q        <= DIR_NONE;
            center_pulse <= 1'b0;
            tick_cnt     <= '0;
            move_tick    <= 1'b0;
        end else begin
            stable_d     <= stable;
            dir_q        <= dir_next;
            center_pulse <= rise[0];
            if (!tick_en) begin
                tick_cnt  <= '0;
                move_tick <= 1'b0;
            end else if (tick_cnt == TICK_LAST) begin
                tick_cnt  <= '0;
                move_tick <= 1'b1;
            end else begin
                tick_cnt  <= tick_cnt + CNT_W'(1);
                move_tick <= 1'b0;
            end
        end
    end

    assign Left  = dir_q[3];
    assign Up    = dir_q[2];
    assign Right = dir_q[1];
    assign Down  = dir_q[0];

endmodule
